// File: rtl/term_rx_dispatch.sv
// rtl/term_rx_dispatch.sv - UART byte FIFO and paced putchar/clear-home dispatcher
//
// Buffers bytes from the UART receiver stream in a small FIFO and hands them to
// the character engine one at a time. Form-feed (0x0C) becomes a clear-home
// pulse. NUL and DEL are dropped. Every other byte becomes a putchar pulse.
// The engine has no busy flag, so each pulse is followed by a fixed idle gap.
//
// Optional feature macro: TERM_ESC_CLEAR_EN
//   When defined, the sequence ESC [ 2 J is also decoded into a clear-home.
//
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   s_axis_tdata   received byte
//   s_axis_tvalid  received byte valid
//   s_axis_tready  FIFO can accept (low while in reset)
//   o_putchar      one-cycle pulse: draw o_char
//   o_clearhome    one-cycle pulse: clear screen, cursor home
//   o_char         character for o_putchar, held until the next dispatch
//   o_busy         FIFO non-empty or dispatcher not idle
//   o_level        FIFO occupancy
module term_rx_dispatch #(
    parameter int          DEPTH_LOG2  = 4,
    parameter logic [23:0] PUTCHAR_GAP = 24'd2000,
    parameter logic [23:0] CLEAR_GAP   = 24'd600000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  o_putchar,
    output logic                  o_clearhome,
    output logic [7:0]            o_char,
    output logic                  o_busy,
    output logic [DEPTH_LOG2:0]   o_level
);

    localparam int                DEPTH      = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_DROP  = 2'd0,
        K_PUT   = 2'd1,
        K_CLEAR = 2'd2
    } kind_t;

    function automatic kind_t f_classify(input logic [7:0] b);
        if (b == 8'h00 || b == 8'h7F) begin
            return K_DROP;
        end else if (b == 8'h0C) begin
            return K_CLEAR;
        end else begin
            return K_PUT;
        end
    endfunction

    // ---------------- FIFO ----------------
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_rdy_en;   // holds tready low until the first edge after reset
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic                  w_full;
    logic [7:0]            w_head;

    assign w_empty       = (r_level == '0);
    assign w_full        = (r_level == LEVEL_FULL);
    assign s_axis_tready = r_rdy_en && !w_full;
    assign w_push        = s_axis_tvalid && s_axis_tready;
    assign w_head        = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // ---------------- Dispatcher ----------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_clear_kind;      // 1: pending dispatch is clear-home, 0: putchar
    logic        w_clear_kind_nxt;
    logic [7:0]  r_char;
    logic [7:0]  w_char_nxt;
    logic [23:0] r_cnt;
    logic [23:0] w_cnt_nxt;
    logic        r_putchar;
    logic        w_putchar_nxt;
    logic        r_clearhome;
    logic        w_clearhome_nxt;
    kind_t       w_kind;

`ifdef TERM_ESC_CLEAR_EN
    // Progress through ESC [ 2 J: number of sequence bytes already consumed.
    localparam logic [1:0] ESC_NONE    = 2'd0;
    localparam logic [1:0] ESC_GOT_ESC = 2'd1;
    localparam logic [1:0] ESC_GOT_BRK = 2'd2;
    localparam logic [1:0] ESC_GOT_2   = 2'd3;
    logic [1:0] r_esc;
    logic [1:0] w_esc_nxt;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_clear_kind_nxt = r_clear_kind;
        w_char_nxt       = r_char;
        w_cnt_nxt        = r_cnt;
        w_putchar_nxt    = 1'b0;
        w_clearhome_nxt  = 1'b0;
        w_pop            = 1'b0;
        w_kind           = K_DROP;
`ifdef TERM_ESC_CLEAR_EN
        w_esc_nxt        = r_esc;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
`ifdef TERM_ESC_CLEAR_EN
                    if (r_esc == ESC_GOT_ESC && w_head == 8'h5B) begin
                        w_esc_nxt = ESC_GOT_BRK;
                    end else if (r_esc == ESC_GOT_BRK && w_head == 8'h32) begin
                        w_esc_nxt = ESC_GOT_2;
                    end else if (r_esc == ESC_GOT_2 && w_head == 8'h4A) begin
                        w_esc_nxt = ESC_NONE;
                        w_kind    = K_CLEAR;
                    end else if (w_head == 8'h1B) begin
                        // A fresh ESC (also one that breaks a partial sequence) re-arms.
                        w_esc_nxt = ESC_GOT_ESC;
                    end else begin
                        w_esc_nxt = ESC_NONE;
                        w_kind    = f_classify(w_head);
                    end
`else
                    w_kind = f_classify(w_head);
`endif
                    case (w_kind)
                        K_PUT: begin
                            w_clear_kind_nxt = 1'b0;
                            w_char_nxt       = w_head;
                            w_state_nxt      = S_ISSUE;
                        end
                        K_CLEAR: begin
                            w_clear_kind_nxt = 1'b1;
                            w_state_nxt      = S_ISSUE;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                // Pulses are registered, so they appear in the first WAIT cycle.
                w_putchar_nxt   = !r_clear_kind;
                w_clearhome_nxt = r_clear_kind;
                w_cnt_nxt       = r_clear_kind ? CLEAR_GAP : PUTCHAR_GAP;
                w_state_nxt     = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 24'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 24'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_clear_kind <= 1'b0;
            r_char       <= 8'h00;
            r_cnt        <= 24'd0;
            r_putchar    <= 1'b0;
            r_clearhome  <= 1'b0;
`ifdef TERM_ESC_CLEAR_EN
            r_esc        <= ESC_NONE;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_clear_kind <= w_clear_kind_nxt;
            r_char       <= w_char_nxt;
            r_cnt        <= w_cnt_nxt;
            r_putchar    <= w_putchar_nxt;
            r_clearhome  <= w_clearhome_nxt;
`ifdef TERM_ESC_CLEAR_EN
            r_esc        <= w_esc_nxt;
`endif
        end
    end

    assign o_putchar   = r_putchar;
    assign o_clearhome = r_clearhome;
    assign o_char      = r_char;
    assign o_busy      = !w_empty || (r_state != S_IDLE);
    assign o_level     = r_level;

endmodule

// File: tb/tb_term_rx_dispatch.sv
// tb/tb_term_rx_dispatch.sv - self-checking bench for term_rx_dispatch
module tb_term_rx_dispatch;

    localparam int          DL    = 4;
    localparam int          DEPTH = 16;
    localparam int          PG    = 5;
    localparam int          CG    = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic       o_putchar;
    logic       o_clearhome;
    logic [7:0] o_char;
    logic       o_busy;
    logic [DL:0] o_level;

    term_rx_dispatch #(
        .DEPTH_LOG2  (DL),
        .PUTCHAR_GAP (24'(PG)),
        .CLEAR_GAP   (24'(CG))
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .o_putchar     (o_putchar),
        .o_clearhome   (o_clearhome),
        .o_char        (o_char),
        .o_busy        (o_busy),
        .o_level       (o_level)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Timeline view: a byte popped at edge P dispatches a pulse visible after
    // edge P+1, and the dispatcher may pop again at edge P+gap+3. Dropped bytes
    // let the next pop happen at edge P+1.
    logic [7:0] q [$];
    int         cyc = 0;
    int         idle_from = 0;
    int         pulse_edge = -1;
    int         pulse_kind = 0;
    int         last_push_cyc = 0;
    bit         ready_en = 1'b0;
    logic [7:0] exp_char = 8'h00;
    int         esc = 0;
    logic [7:0] m_b;
    int         m_k;
    bit         m_pre;

    function automatic int plain_kind(input logic [7:0] b);
        if (b == 8'h00 || b == 8'h7F) return 0;
        if (b == 8'h0C) return 2;
        return 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            ready_en   = 1'b0;
            idle_from  = 0;
            pulse_edge = -1;
            pulse_kind = 0;
            exp_char   = 8'h00;
            esc        = 0;
        end else begin
            cyc++;
            m_pre = ready_en && (q.size() < DEPTH);
            if (q.size() > 0 && cyc >= idle_from) begin
                m_b = q.pop_front();
`ifdef TERM_ESC_CLEAR_EN
                m_k = 0;
                if (esc == 1 && m_b == 8'h5B) esc = 2;
                else if (esc == 2 && m_b == 8'h32) esc = 3;
                else if (esc == 3 && m_b == 8'h4A) begin esc = 0; m_k = 2; end
                else if (m_b == 8'h1B) esc = 1;
                else begin esc = 0; m_k = plain_kind(m_b); end
`else
                m_k = plain_kind(m_b);
`endif
                if (m_k == 0) begin
                    idle_from = cyc + 1;
                end else begin
                    pulse_edge = cyc + 1;
                    pulse_kind = m_k;
                    idle_from  = cyc + ((m_k == 1) ? PG : CG) + 3;
                    if (m_k == 1) exp_char = m_b;
                end
            end
            if (s_axis_tvalid && m_pre) begin
                q.push_back(s_axis_tdata);
                last_push_cyc = cyc;
            end
            ready_en = 1'b1;
        end
    end

    // ---------------- compare process and pulse log ----------------
    int         p_cyc  [$];
    int         p_kind [$];
    logic [7:0] p_char [$];
    int         max_level = 0;

    always @(negedge clk) begin
        if (started) begin
            chk("putchar",   32'(o_putchar),     32'(cyc == pulse_edge && pulse_kind == 1));
            chk("clearhome", 32'(o_clearhome),   32'(cyc == pulse_edge && pulse_kind == 2));
            chk("char",      32'(o_char),        32'(exp_char));
            chk("level",     32'(o_level),       32'(q.size()));
            chk("tready",    32'(s_axis_tready), 32'(ready_en && q.size() < DEPTH));
            chk("busy",      32'(o_busy),        32'(q.size() != 0 || cyc < idle_from - 1));
            if (o_putchar || o_clearhome) begin
                p_cyc.push_back(cyc);
                p_kind.push_back(o_putchar ? 1 : 2);
                p_char.push_back(o_char);
            end
            if (int'(o_level) > max_level) max_level = int'(o_level);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [7:0] b);
        bit ok;
        int n = 0;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        forever begin
            ok = s_axis_tready;
            @(negedge clk);
            if (ok) break;
            n++;
            if (n > 5000) begin
                chk("push_timeout", 32'(n), 32'd0);
                break;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        s_axis_tvalid = 1'b0;
        while (o_busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) chk("drain_timeout", 32'(n), 32'd0);
        #1;
    endtask

    task automatic clear_log();
        p_cyc.delete();
        p_kind.delete();
        p_char.delete();
    endtask

    function automatic logic [7:0] pick_byte();
        case ($urandom_range(0, 9))
            0: return 8'h00;
            1: return 8'h7F;
            2: return ($urandom_range(0, 3) == 0) ? 8'h0C : 8'h41;
            3: return 8'h1B;
            4: return 8'h5B;
            5: return 8'h32;
            6: return 8'h4A;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        logic [7:0] seq [4];
        repeat (3) @(negedge clk);
        started = 1'b1;
        #1;
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_level",  32'(o_level),       32'd0);
        chk("rst_busy",   32'(o_busy),        32'd0);
        chk("rst_char",   32'(o_char),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_tready", 32'(s_axis_tready), 32'd1);

        // single printable byte: latency and gap
        clear_log();
        push(8'h41);
        drain();
        chk("t1_count", 32'(p_cyc.size()), 32'd1);
        chk("t1_lat",   32'(p_cyc[0] - last_push_cyc), 32'd2);
        chk("t1_char",  32'(p_char[0]), 32'h41);
        chk("t1_idle",  32'(cyc - last_push_cyc), 32'(PG + 3));

        // 20-byte burst with tvalid held high
        clear_log();
        max_level = 0;
        for (int i = 0; i < 20; i++) push(8'(8'h30 + i));
        drain();
        chk("burst_count", 32'(p_cyc.size()), 32'd20);
        chk("burst_maxlvl", 32'(max_level), 32'd16);
        for (int i = 0; i < 20; i++) begin
            chk("burst_char", 32'(p_char[i]), 32'(8'h30 + i));
            if (i > 0) chk("burst_space", 32'(p_cyc[i] - p_cyc[i-1]), 32'(PG + 3));
        end

        // putchar, clear-home, putchar
        clear_log();
        push(8'h41); push(8'h0C); push(8'h42);
        drain();
        chk("mix_count", 32'(p_cyc.size()), 32'd3);
        chk("mix_k0", 32'(p_kind[0]), 32'd1);
        chk("mix_k1", 32'(p_kind[1]), 32'd2);
        chk("mix_k2", 32'(p_kind[2]), 32'd1);
        chk("mix_c2", 32'(p_char[2]), 32'h42);
        chk("mix_sp0", 32'(p_cyc[1] - p_cyc[0]), 32'(PG + 3));
        chk("mix_sp1", 32'(p_cyc[2] - p_cyc[1]), 32'd103);

        // discarded bytes
        clear_log();
        push(8'h00); push(8'h7F); push(8'h5A);
        drain();
        chk("drop_count", 32'(p_cyc.size()), 32'd1);
        chk("drop_char",  32'(p_char[0]), 32'h5A);
        chk("drop_lat",   32'(p_cyc[0] - last_push_cyc), 32'd2);

        // reset mid-WAIT with bytes queued
        clear_log();
        for (int i = 0; i < 6; i++) push(8'(8'h61 + i));
        s_axis_tvalid = 1'b0;
        chk("mid_level5", 32'(o_level), 32'd5);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_put",    32'(o_putchar),     32'd0);
        chk("mid_clr",    32'(o_clearhome),   32'd0);
        chk("mid_busy",   32'(o_busy),        32'd0);
        chk("mid_level",  32'(o_level),       32'd0);
        chk("mid_tready", 32'(s_axis_tready), 32'd0);
        chk("mid_char",   32'(o_char),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        repeat (100) @(negedge clk);
        #1;
        chk("mid_nopulse", 32'(p_cyc.size()), 32'd0);
        chk("mid_level_after", 32'(o_level), 32'd0);

        // escape sequences
        seq[0] = 8'h1B; seq[1] = 8'h5B; seq[2] = 8'h32; seq[3] = 8'h4A;
        clear_log();
        for (int i = 0; i < 4; i++) push(seq[i]);
        drain();
`ifdef TERM_ESC_CLEAR_EN
        chk("esc_count", 32'(p_cyc.size()), 32'd1);
        chk("esc_kind",  32'(p_kind[0]), 32'd2);
`else
        chk("esc_count", 32'(p_cyc.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("esc_char", 32'(p_char[i]), 32'(seq[i]));
`endif
        clear_log();
        push(8'h1B); push(8'h5B); push(8'h33);
        drain();
`ifdef TERM_ESC_CLEAR_EN
        chk("escmis_count", 32'(p_cyc.size()), 32'd1);
        chk("escmis_char",  32'(p_char[0]), 32'h33);
`else
        chk("escmis_count", 32'(p_cyc.size()), 32'd3);
        chk("escmis_char",  32'(p_char[2]), 32'h33);
`endif

        // randomized traffic against the model, with one reset in the middle
        for (int it = 0; it < 300; it++) begin
            if (it == 150) begin
                s_axis_tvalid = 1'b0;
                #1 rst_n = 1'b0;
                #1 chk("rnd_rst_level", 32'(o_level), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
            push(pick_byte());
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
